// File: rtl/vga_pkg.sv
// Shared VGA definitions used by the timing generator and the fetch/align stage:
// default active area, default sync polarity, image-centring helpers and the
// side-band bundle that travels alongside each pixel.
package vga_pkg;

  localparam int   VGA_H_ACT    = 640;
  localparam int   VGA_V_ACT    = 480;
  localparam logic VGA_SYNC_ACT = 1'b0;

  // Per-pixel side-band carried in step with the BRAM read.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic videoon;
    logic in_img;
  } sideband_t;

  // Left margin that centres an image of img_w pixels on an h_act-wide line.
  function automatic int x_off(input int h_act, input int img_w);
    return (h_act - img_w) / 2;
  endfunction

  // Top margin that centres an image of img_h lines on a v_act-tall frame.
  function automatic int y_off(input int v_act, input int img_h);
    return (v_act - img_h) / 2;
  endfunction

endpackage

// File: rtl/img_fetch_align_if.sv
// Block-RAM read port between the fetch stage (master) and the image memory
// (slave). Read data is valid one clk after address/enable.
interface img_fetch_align_if #(
  parameter int ADDR_W = 16,
  parameter int RGB_W  = 12
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [RGB_W-1:0]  mem_rdata;

  modport master (
    output mem_addr,
    output mem_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_en,
    output mem_rdata
  );

endinterface

// File: rtl/pix_delay_line.sv
// Pixel-enable qualified shift register. Each ce pulse moves the data one
// stage along; between pulses every stage holds.
module pix_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Next contents: new sample enters stage 0, older samples move one stage on.
  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Shift on ce only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this is a handful of control flops, not a RAM, so every stage is
      // reset to the idle pattern; a data memory would be left unreset.
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= RST_VAL;
      end
    end else if (ce) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/img_fetch_align.sv
// Pixel fetch and alignment between the VGA timing generator and the DAC.
// Centres an IMG_W x IMG_H image in the active area, walks the BRAM with an
// incrementing address (no multiplier), and delays syncs/blanking so they
// leave in step with the returned pixel data, two pix_ce pulses after input.
module img_fetch_align
  import vga_pkg::*;
#(
  parameter int               IMG_W    = 300,
  parameter int               IMG_H    = 200,
  parameter int               H_ACT    = VGA_H_ACT,
  parameter int               V_ACT    = VGA_V_ACT,
  parameter int               ADDR_W   = 16,
  parameter int               RGB_W    = 12,
  parameter logic [RGB_W-1:0] BORDER   = '0,
  parameter logic             SYNC_ACT = VGA_SYNC_ACT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                videoon_in,
  input  logic [9:0]          x_in,
  input  logic [9:0]          y_in,
  img_fetch_align_if.master   mem,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [RGB_W-1:0]    rgb_out,
  output logic                frame_start,
  output logic                addr_err
);

  localparam int X_OFF  = x_off(H_ACT, IMG_W);
  localparam int Y_OFF  = y_off(V_ACT, IMG_H);
  localparam int PIXELS = IMG_W * IMG_H;

  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + IMG_W);
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + IMG_H);

  // The counter needs one extra bit so it can sit at PIXELS when the image
  // exactly fills the address space.
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W+1)'(PIXELS);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam sideband_t SB_IDLE = '{
    hsync:   ~SYNC_ACT,
    vsync:   ~SYNC_ACT,
    videoon: 1'b0,
    in_img:  1'b0
  };

  if (longint'(PIXELS) > (longint'(1) << ADDR_W)) begin : g_size_check
    $error("img_fetch_align: IMG_W*IMG_H does not fit in ADDR_W address bits");
  end

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              addr_err_q, addr_err_d;
  logic              frame_start_q, frame_start_d;
  logic              hsync_out_q, hsync_out_d;
  logic              vsync_out_q, vsync_out_d;
  logic [RGB_W-1:0]  rgb_out_q, rgb_out_d;

  logic              origin;
  logic              in_img;
  logic              fetch_act;
  logic [ADDR_W:0]   base;
  sideband_t         sb_in;
  sideband_t         sb_q;

  // The (0,0) sample both starts the first frame and restarts every later one,
  // so it is handled as a RUN sample even while the FSM still reads WAIT.
  assign origin    = (x_in == '0) && (y_in == '0);
  assign in_img    = videoon_in &&
                     (x_in >= X_LO) && (x_in < X_HI) &&
                     (y_in >= Y_LO) && (y_in < Y_HI);
  assign fetch_act = (state_q == ST_RUN) || origin;

  // FSM, address counter, read request and frame marker.
  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_en_d      = mem_en_q;
    addr_err_d    = addr_err_q;
    frame_start_d = 1'b0;
    base          = cnt_q;

    if (pix_ce) begin
      if (fetch_act) begin
        state_d       = ST_RUN;
        frame_start_d = origin;
        // Clear wins over increment: an in-image origin reads address 0.
        base          = origin ? '0 : cnt_q;
        cnt_d         = base;
        mem_en_d      = in_img;
        if (in_img) begin
          if (base == CNT_MAX) begin
            addr_err_d = 1'b1;
            mem_addr_d = LAST_ADDR;
          end else begin
            mem_addr_d = base[ADDR_W-1:0];
            cnt_d      = base + CNT_ONE;
          end
        end
      end else begin
        mem_en_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  // Stage-1 side-band: idle pattern until the first origin has been seen.
  always_comb begin
    sb_in = SB_IDLE;
    if (fetch_act) begin
      sb_in.hsync   = hsync_in;
      sb_in.vsync   = vsync_in;
      sb_in.videoon = videoon_in;
      sb_in.in_img  = in_img;
    end
  end

  pix_delay_line #(
    .WIDTH   ($bits(sideband_t)),
    .DEPTH   (1),
    .RST_VAL (SB_IDLE)
  ) u_sb_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce),
    .d     (sb_in),
    .q     (sb_q)
  );

  // Stage-2 output mux: BRAM data inside the image, border colour in the rest
  // of active video, black in blanking. Syncs pass through unchanged.
  always_comb begin
    hsync_out_d = hsync_out_q;
    vsync_out_d = vsync_out_q;
    rgb_out_d   = rgb_out_q;
    if (pix_ce) begin
      hsync_out_d = sb_q.hsync;
      vsync_out_d = sb_q.vsync;
      if (sb_q.in_img) begin
        rgb_out_d = mem.mem_rdata;
      end else if (sb_q.videoon) begin
        rgb_out_d = BORDER;
      end else begin
        rgb_out_d = '0;
      end
    end
  end

  // State registers; reset forces the idle/black picture immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      mem_en_q      <= 1'b0;
      addr_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_out_q   <= ~SYNC_ACT;
      vsync_out_q   <= ~SYNC_ACT;
      rgb_out_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values and the order of these lines does not matter.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_en_q      <= mem_en_d;
      addr_err_q    <= addr_err_d;
      frame_start_q <= frame_start_d;
      hsync_out_q   <= hsync_out_d;
      vsync_out_q   <= vsync_out_d;
      rgb_out_q     <= rgb_out_d;
    end
  end

  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_en   = mem_en_q;
  assign hsync_out    = hsync_out_q;
  assign vsync_out    = vsync_out_q;
  assign rgb_out      = rgb_out_q;
  assign frame_start  = frame_start_q;
  assign addr_err     = addr_err_q;

endmodule
